// File: rtl/tone_driver_if.sv
// rtl/tone_driver_if.sv - tick/mute inputs and speaker outputs of the tone driver
interface tone_driver_if;
  logic       at_max;
  logic       mute;
  logic       speaker;
  logic       square;
  logic [3:0] vol;
  logic       active;

  // Game-side logic: drives the oscillator tick and mute, watches the pin outputs.
  modport master (
    output at_max,
    output mute,
    input  speaker,
    input  square,
    input  vol,
    input  active
  );

  // Tone driver itself.
  modport slave (
    input  at_max,
    input  mute,
    output speaker,
    output square,
    output vol,
    output active
  );
endinterface

// File: rtl/tone_driver.sv
// rtl/tone_driver.sv - square-wave tone with decaying PWM volume and silence timeout
module tone_driver #(
  parameter int         SILENCE_CYCLES = 512,
  parameter int         DECAY_EDGES    = 64,
  parameter logic [3:0] VOL_MAX        = 4'd15,
  parameter logic [3:0] VOL_MIN        = 4'd1
) (
  input  logic        clk,
  input  logic        nRst,
  tone_driver_if.slave bus
);

  localparam int SIL_W  = (SILENCE_CYCLES > 1) ? $clog2(SILENCE_CYCLES) : 1;
  localparam int EDGE_W = (DECAY_EDGES > 1) ? $clog2(DECAY_EDGES) : 1;
  localparam logic [SIL_W-1:0]  SIL_LAST  = SIL_W'(SILENCE_CYCLES - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(DECAY_EDGES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                square_q, square_d;
  logic [3:0]          vol_q, vol_d;
  logic [3:0]          pwm_cnt_q, pwm_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [SIL_W-1:0]    sil_cnt_q, sil_cnt_d;

  // State and counter registers; reset clears everything, including mid-tone.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= IDLE;
      square_q   <= 1'b0;
      vol_q      <= 4'd0;
      pwm_cnt_q  <= 4'd0;
      edge_cnt_q <= '0;
      sil_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      square_q   <= square_d;
      vol_q      <= vol_d;
      pwm_cnt_q  <= pwm_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sil_cnt_q  <= sil_cnt_d;
    end
  end

  // Next-state logic: mute beats a tick, a tick beats the silence timeout.
  always_comb begin
    state_d    = state_q;
    square_d   = square_q;
    vol_d      = vol_q;
    pwm_cnt_d  = pwm_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sil_cnt_d  = sil_cnt_q;

    case (state_q)
      IDLE: begin
        square_d   = 1'b0;
        vol_d      = 4'd0;
        pwm_cnt_d  = 4'd0;
        edge_cnt_d = '0;
        sil_cnt_d  = '0;
        if (bus.at_max && !bus.mute) begin
          // Entry tick starts the tone but is not counted toward decay.
          state_d  = PLAY;
          square_d = 1'b1;
          vol_d    = VOL_MAX;
        end
      end

      PLAY: begin
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        if (bus.mute) begin
          state_d    = IDLE;
          square_d   = 1'b0;
          vol_d      = 4'd0;
          pwm_cnt_d  = 4'd0;
          edge_cnt_d = '0;
          sil_cnt_d  = '0;
        end else if (bus.at_max) begin
          square_d  = ~square_q;
          sil_cnt_d = '0;
          if (edge_cnt_q == EDGE_LAST) begin
            edge_cnt_d = '0;
            if (vol_q > VOL_MIN) begin
              vol_d = vol_q - 4'd1;
            end
          end else begin
            edge_cnt_d = edge_cnt_q + 1'b1;
          end
        end else if (sil_cnt_q == SIL_LAST) begin
          state_d    = IDLE;
          square_d   = 1'b0;
          vol_d      = 4'd0;
          pwm_cnt_d  = 4'd0;
          edge_cnt_d = '0;
          sil_cnt_d  = '0;
        end else begin
          sil_cnt_d = sil_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers; speaker gating has no input path.
  assign bus.square  = square_q;
  assign bus.vol     = vol_q;
  assign bus.active  = (state_q == PLAY);
  assign bus.speaker = square_q && (state_q == PLAY) && (pwm_cnt_q < vol_q);

endmodule

// File: tb/tb_tone_driver.sv
// tb/tb_tone_driver.sv - randomized self-checking bench for tone_driver
module tb_tone_driver;

  localparam int SIL  = 512;
  localparam int DEC  = 64;
  localparam int VMAX = 15;
  localparam int VMIN = 1;

  logic clk;
  logic nRst;
  int   total;
  int   bad;

  tone_driver_if ifc ();

  tone_driver #(
    .SILENCE_CYCLES (SIL),
    .DECAY_EDGES    (DEC),
    .VOL_MAX        (4'(VMAX)),
    .VOL_MIN        (4'(VMIN))
  ) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a tone is described by how many ticks it has seen since
  // it started, how long since the last tick, and how old it is.
  bit m_play;
  int m_ticks;
  int m_quiet;
  int m_age;

  task automatic model_step(input logic a, input logic m);
    if (!nRst) begin
      m_play = 0; m_ticks = 0; m_quiet = 0; m_age = 0;
    end else if (!m_play) begin
      if (a && !m) begin
        m_play = 1; m_ticks = 0; m_quiet = 0; m_age = 0;
      end
    end else if (m) begin
      m_play = 0;
    end else begin
      m_age++;
      if (a) begin
        m_ticks++;
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet >= SIL) m_play = 0;
      end
    end
  endtask

  // Expected {speaker, square, vol, active}.
  function automatic logic [6:0] model_out();
    int lvl;
    logic sq;
    if (!m_play) return 7'd0;
    lvl = VMAX - m_ticks / DEC;
    if (lvl < VMIN) lvl = VMIN;
    sq = (m_ticks % 2) == 0;
    return {sq && ((m_age % 16) < lvl), sq, 4'(lvl), 1'b1};
  endfunction

  function automatic logic [6:0] dut_out();
    return {ifc.speaker, ifc.square, ifc.vol, ifc.active};
  endfunction

  // One clock cycle with the given inputs; outputs are then sampled at the falling edge.
  task automatic cyc(input logic a, input logic m);
    ifc.at_max = a;
    ifc.mute   = m;
    @(posedge clk);
    model_step(a, m);
    @(negedge clk);
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      total++;
      if (dut_out() !== 7'd0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=0000000", i, dut_out());
      end
    end
    nRst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0);
      total++;
      if (dut_out() !== 7'd0) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got=%b want=0000000", i, dut_out());
      end
    end
  endtask

  task automatic test_start();
    int hi;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    total++;
    if ({ifc.active, ifc.square, ifc.vol} !== {1'b1, 1'b1, 4'd15}) begin
      bad++;
      $display("FAIL start_entry got active=%b square=%b vol=%0d want 1 1 15",
               ifc.active, ifc.square, ifc.vol);
    end
    hi = (ifc.speaker === 1'b1) ? 1 : 0;
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 1'b0);
      if (ifc.speaker === 1'b1) hi++;
    end
    total++;
    if (hi != 15) begin
      bad++;
      $display("FAIL start_duty got=%0d want=15", hi);
    end
    for (int i = 0; i < 24; i++) begin
      cyc(($urandom_range(0, 3) == 0), 1'b0);
      total++;
      if (dut_out() !== model_out()) begin
        bad++;
        $display("FAIL start_track cyc=%0d got=%b want=%b", i, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_decay();
    logic sq_prev;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int t = 1; t <= DEC; t++) begin
      int gap = $urandom_range(80, 100);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0);
      sq_prev = ifc.square;
      cyc(1'b1, 1'b0);
      total++;
      if (ifc.square !== ~sq_prev) begin
        bad++;
        $display("FAIL decay_toggle tick=%0d got=%b want=%b", t, ifc.square, ~sq_prev);
      end
    end
    total++;
    if (ifc.vol !== 4'd14) begin
      bad++;
      $display("FAIL decay_first_step got=%0d want=14", ifc.vol);
    end
    for (int t = 0; t < 15 * DEC; t++) begin
      int gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      total++;
      if (dut_out() !== model_out() || ifc.vol === 4'd0) begin
        bad++;
        $display("FAIL decay_track tick=%0d got=%b want=%b", t, dut_out(), model_out());
      end
    end
    total++;
    if (ifc.vol !== 4'(VMIN)) begin
      bad++;
      $display("FAIL decay_floor got=%0d want=%0d", ifc.vol, VMIN);
    end
  endtask

  task automatic test_timeout();
    cyc(1'b1, 1'b0);
    for (int k = 1; k <= SIL; k++) begin
      cyc(1'b0, 1'b0);
      if (k == SIL - 1) begin
        total++;
        if (ifc.active !== 1'b1) begin
          bad++;
          $display("FAIL timeout_last_active got=%b want=1", ifc.active);
        end
      end
      if (k == SIL) begin
        total++;
        if ({ifc.active, ifc.square, ifc.vol} !== 6'd0) begin
          bad++;
          $display("FAIL timeout_idle got active=%b square=%b vol=%0d want 0 0 0",
                   ifc.active, ifc.square, ifc.vol);
        end
      end
    end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    for (int k = 1; k < SIL; k++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    total++;
    if (ifc.active !== 1'b1 || dut_out() !== model_out()) begin
      bad++;
      $display("FAIL timeout_rescue got=%b want=%b", dut_out(), model_out());
    end
    for (int k = 1; k <= SIL; k++) begin
      cyc(1'b0, 1'b0);
      if (k == SIL - 1 || k == SIL) begin
        total++;
        if (ifc.active !== (k == SIL - 1)) begin
          bad++;
          $display("FAIL timeout_restart k=%0d got=%b want=%b", k, ifc.active, (k == SIL - 1));
        end
      end
    end
  endtask

  task automatic test_mute();
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(($urandom_range(0, 1) == 1), 1'b0);
    cyc(1'b1, 1'b1);
    total++;
    if (dut_out() !== 7'd0) begin
      bad++;
      $display("FAIL mute_with_tick got=%b want=0000000", dut_out());
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1);
      total++;
      if (dut_out() !== 7'd0) begin
        bad++;
        $display("FAIL mute_ignore cyc=%0d got=%b want=0000000", i, dut_out());
      end
    end
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    total++;
    if ({ifc.active, ifc.square, ifc.vol} !== {1'b1, 1'b1, 4'd15}) begin
      bad++;
      $display("FAIL mute_restart got active=%b square=%b vol=%0d want 1 1 15",
               ifc.active, ifc.square, ifc.vol);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 3 * DEC; i++) cyc(1'b1, 1'b0);
    total++;
    if (ifc.vol !== 4'd12) begin
      bad++;
      $display("FAIL resetmid_setup got=%0d want=12", ifc.vol);
    end
    nRst = 1'b0;
    cyc(1'b1, 1'b0);
    nRst = 1'b1;
    total++;
    if (dut_out() !== 7'd0) begin
      bad++;
      $display("FAIL resetmid_clear got=%b want=0000000", dut_out());
    end
    cyc(1'b1, 1'b0);
    total++;
    if (ifc.vol !== 4'd15 || ifc.active !== 1'b1) begin
      bad++;
      $display("FAIL resetmid_fresh got vol=%0d active=%b want 15 1", ifc.vol, ifc.active);
    end
    for (int i = 0; i < DEC - 1; i++) cyc(1'b1, 1'b0);
    total++;
    if (ifc.vol !== 4'd15) begin
      bad++;
      $display("FAIL resetmid_edge_cnt_63 got=%0d want=15", ifc.vol);
    end
    cyc(1'b1, 1'b0);
    total++;
    if (ifc.vol !== 4'd14) begin
      bad++;
      $display("FAIL resetmid_edge_cnt_64 got=%0d want=14", ifc.vol);
    end
  endtask

  task automatic test_random();
    logic m;
    m = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) m = ~m;
      if (i % 1000 == 999) nRst = 1'b0;
      cyc(($urandom_range(0, 9) < 2), m);
      nRst = 1'b1;
      total++;
      if (dut_out() !== model_out()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", i, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    nRst = 1'b0;
    ifc.at_max = 1'b0;
    ifc.mute = 1'b0;
    m_play = 0; m_ticks = 0; m_quiet = 0; m_age = 0;
    @(negedge clk);
    test_reset();
    test_start();
    test_decay();
    test_timeout();
    test_mute();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
